// File: rtl/bicintp_coef_addr_gen.sv
// Bicubic scaler coefficient-address initiator: walks output lines/pixels
// in 11.8 fixed point and drives the weight-ROM v-tap and h-phase reads.
module bicintp_coef_addr_gen #(
    parameter int DIM_W     = 11,
    parameter int FRAC_W    = 8,
    parameter int VWAIT_CYC = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rstn,
    input  logic             frame_start,
    input  logic [DIM_W-1:0] out_hsize,
    input  logic [DIM_W-1:0] out_vsize,
    input  logic [15:0]      h_step,
    input  logic [15:0]      v_step,
    input  logic             pix_ready,
    output logic             pix_valid,
    output logic [DIM_W-1:0] src_x,
    output logic [DIM_W-1:0] src_y,
    output logic [4:0]       rom_h_rd_addr,
    output logic [4:0]       rom_v_rd_addr,
    output logic             rom_v_rd_enb,
    output logic             coef_y_vld,
    output logic             busy,
    output logic             frame_done
);

    localparam int ACC_W = DIM_W + FRAC_W;
    localparam int CNT_W = (VWAIT_CYC > 4) ? $clog2(VWAIT_CYC) : 2;
    localparam logic [CNT_W-1:0] TAP_LAST  = CNT_W'(3);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(VWAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VLOAD,
        S_VWAIT,
        S_HRUN,
        S_LEND,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [DIM_W-1:0] hsize_q, hsize_d;
    logic [DIM_W-1:0] vsize_q, vsize_d;
    logic [15:0]      hstep_q, hstep_d;
    logic [15:0]      vstep_q, vstep_d;
    logic [ACC_W-1:0] h_acc_q, h_acc_d;
    logic [ACC_W-1:0] v_acc_q, v_acc_d;
    logic [DIM_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [DIM_W-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [ACC_W-1:0] h_inc;
    logic [ACC_W-1:0] v_inc;
    logic             pix_last;
    logic             line_last;

    assign h_inc     = ACC_W'(hstep_q);
    assign v_inc     = ACC_W'(vstep_q);
    assign pix_last  = (pix_cnt_q == hsize_q - DIM_W'(1));
    assign line_last = (line_cnt_q == vsize_q - DIM_W'(1));

    // Coordinates and phases are plain slices of the registered accumulators.
    assign src_x         = h_acc_q[ACC_W-1:FRAC_W];
    assign src_y         = v_acc_q[ACC_W-1:FRAC_W];
    assign rom_h_rd_addr = h_acc_q[FRAC_W-1 -: 5];
    assign rom_v_rd_addr = {v_acc_q[FRAC_W-1 -: 3], cnt_q[1:0]};
    assign rom_v_rd_enb  = (state_q == S_VLOAD);
    assign pix_valid     = (state_q == S_HRUN);
    assign coef_y_vld    = (state_q == S_HRUN);
    assign busy          = (state_q != S_IDLE);
    assign frame_done    = (state_q == S_DONE);

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q    <= S_IDLE;
            hsize_q    <= '0;
            vsize_q    <= '0;
            hstep_q    <= '0;
            vstep_q    <= '0;
            h_acc_q    <= '0;
            v_acc_q    <= '0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            hsize_q    <= hsize_d;
            vsize_q    <= vsize_d;
            hstep_q    <= hstep_d;
            vstep_q    <= vstep_d;
            h_acc_q    <= h_acc_d;
            v_acc_q    <= v_acc_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hsize_d    = hsize_q;
        vsize_d    = vsize_q;
        hstep_d    = hstep_q;
        vstep_d    = vstep_q;
        h_acc_d    = h_acc_q;
        v_acc_d    = v_acc_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    hsize_d    = out_hsize;
                    vsize_d    = out_vsize;
                    hstep_d    = h_step;
                    vstep_d    = v_step;
                    v_acc_d    = '0;
                    line_cnt_d = '0;
                    cnt_d      = '0;
                    // Empty frames finish without touching the ROM.
                    if (out_hsize == '0 || out_vsize == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_VLOAD;
                    end
                end
            end
            S_VLOAD: begin
                if (cnt_q == TAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_VWAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_VWAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d     = '0;
                    h_acc_d   = '0;
                    pix_cnt_d = '0;
                    state_d   = S_HRUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HRUN: begin
                if (pix_ready) begin
                    h_acc_d   = h_acc_q + h_inc;
                    pix_cnt_d = pix_cnt_q + DIM_W'(1);
                    if (pix_last) begin
                        state_d = S_LEND;
                    end
                end
            end
            S_LEND: begin
                v_acc_d    = v_acc_q + v_inc;
                line_cnt_d = line_cnt_q + DIM_W'(1);
                state_d    = line_last ? S_DONE : S_VLOAD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
